// File: rtl/branch_resolve_queue.sv
// Purpose : resolves up to LANES branches per cycle, flags the oldest mispredict as a
//           fetch redirect and queues training records for the BTB/predictor.
// Latency : redirect is registered, one cycle after resolve; a queued record reaches the head the next cycle.
// Backpr. : stall is raised when fewer than LANES slots are free, and all res_* inputs
//           are then ignored; the drain side uses upd_valid/upd_ready.
//
// Ports
//   clk, rst                   clock, synchronous active-low reset
//   res_*                      per-lane resolved instruction, packed lane i at [i*W +: W]
//   stall                      producer must hold inputs this cycle
//   redirect_valid/_pc         one-cycle refetch pulse and corrected PC
//   upd_valid/_ready, upd_*    FIFO head record to BTB/predictor
//   mispred_count              saturating count of acted-on mispredicts
module branch_resolve_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      res_valid,
  input  logic [LANES-1:0]      res_is_branch,
  input  logic [LANES-1:0]      res_taken,
  input  logic [LANES*PC_W-1:0] res_pc,
  input  logic [LANES*PC_W-1:0] res_target,
  input  logic [LANES-1:0]      res_pred_taken,
  input  logic [LANES*PC_W-1:0] res_pred_target,
  output logic                  stall,
  output logic                  redirect_valid,
  output logic [PC_W-1:0]       redirect_pc,
  output logic                  upd_valid,
  input  logic                  upd_ready,
  output logic [PC_W-1:0]       upd_pc,
  output logic                  upd_taken,
  output logic [PC_W-1:0]       upd_target,
  output logic                  upd_mispred,
  output logic [CNT_W-1:0]      mispred_count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
    logic            mispred;
  } rec_t;

  // State
  rec_t            mem_q [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [AW:0]     occ_q, occ_d;
  logic            redir_vld_q, redir_vld_d;
  logic [PC_W-1:0] redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Per-lane unpacked views of the flat input buses
  logic [PC_W-1:0] pc_l   [LANES];
  logic [PC_W-1:0] tgt_l  [LANES];
  logic [PC_W-1:0] ptgt_l [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_unpack
    assign pc_l[g]   = res_pc[g*PC_W +: PC_W];
    assign tgt_l[g]  = res_target[g*PC_W +: PC_W];
    assign ptgt_l[g] = res_pred_target[g*PC_W +: PC_W];
  end

  logic [LANES-1:0] is_br;
  logic [LANES-1:0] mis;
  logic [LANES-1:0] live;
  logic [AW-1:0]    wr_ptr [LANES];
  rec_t             rec    [LANES];
  logic [AW-1:0]    off;
  logic [AW:0]      push_n;
  logic             older_mis;
  logic             acted;
  logic             pop;
  logic [AW:0]      free_slots;

  assign is_br = res_valid & res_is_branch;

  // Stall looks only at registered occupancy, so a pop in the same cycle
  // does not release it; this keeps stall off any combinational path from upd_ready.
  assign free_slots = (AW+1)'(DEPTH) - occ_q;
  assign stall      = free_slots < (AW+1)'(LANES);

  assign upd_valid = (occ_q != '0);
  assign pop       = upd_valid & upd_ready;

  always_comb begin
    mis        = '0;
    live       = '0;
    off        = '0;
    push_n     = '0;
    older_mis  = 1'b0;
    acted      = 1'b0;
    redir_pc_d = '0;
    for (int i = 0; i < LANES; i++) begin
      mis[i] = is_br[i] &
               ((res_pred_taken[i] != res_taken[i]) |
                (res_taken[i] & (ptgt_l[i] != tgt_l[i])));
      // Anything younger than a mispredict is wrong-path and never recorded.
      live[i]           = ~stall & is_br[i] & ~older_mis;
      wr_ptr[i]         = tail_q + off;
      rec[i].pc         = pc_l[i];
      rec[i].taken      = res_taken[i];
      rec[i].target     = tgt_l[i];
      rec[i].mispred    = mis[i];
      if (live[i]) begin
        off    = off + AW'(1);
        push_n = push_n + (AW+1)'(1);
      end
      // Only the first live lane can be a live mispredict, so this picks the oldest.
      if (live[i] & mis[i]) begin
        acted      = 1'b1;
        redir_pc_d = res_taken[i] ? tgt_l[i] : (pc_l[i] + PC_W'(4));
      end
      older_mis = older_mis | mis[i];
    end
  end

  always_comb begin
    head_d      = head_q + AW'(pop);
    tail_d      = tail_q + off;
    occ_d       = occ_q + push_n - (AW+1)'(pop);
    redir_vld_d = acted;
    cnt_d       = (acted && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
      cnt_q       <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      redir_vld_q <= redir_vld_d;
      redir_pc_q  <= redir_pc_d;
      cnt_q       <= cnt_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by occupancy alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (live[i]) begin
        mem_q[wr_ptr[i]] <= rec[i];
      end
    end
  end

  rec_t head_rec;
  assign head_rec = mem_q[head_q];

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign upd_pc         = upd_valid ? head_rec.pc      : '0;
  assign upd_taken      = upd_valid ? head_rec.taken   : 1'b0;
  assign upd_target     = upd_valid ? head_rec.target  : '0;
  assign upd_mispred    = upd_valid ? head_rec.mispred : 1'b0;

  assign redirect_valid = redir_vld_q;
  assign redirect_pc    = redir_pc_q;
  assign mispred_count  = cnt_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int PC_W  = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [LANES-1:0]      res_valid;
  logic [LANES-1:0]      res_is_branch;
  logic [LANES-1:0]      res_taken;
  logic [LANES*PC_W-1:0] res_pc;
  logic [LANES*PC_W-1:0] res_target;
  logic [LANES-1:0]      res_pred_taken;
  logic [LANES*PC_W-1:0] res_pred_target;
  logic                  upd_ready;

  logic                  stall, redirect_valid, upd_valid, upd_taken, upd_mispred;
  logic [PC_W-1:0]       redirect_pc, upd_pc, upd_target;
  logic [15:0]           mispred_count;

  logic                  s_stall, s_redirect_valid, s_upd_valid, s_upd_taken, s_upd_mispred;
  logic [PC_W-1:0]       s_redirect_pc, s_upd_pc, s_upd_target;
  logic [1:0]            s_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.LANES(LANES), .DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_is_branch(res_is_branch), .res_taken(res_taken),
    .res_pc(res_pc), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispred(upd_mispred),
    .mispred_count(mispred_count)
  );

  // Narrow-counter copy fed with the same stimulus, used for saturation.
  branch_resolve_queue #(.LANES(LANES), .DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_is_branch(res_is_branch), .res_taken(res_taken),
    .res_pc(res_pc), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .stall(s_stall), .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .upd_valid(s_upd_valid), .upd_ready(upd_ready), .upd_pc(s_upd_pc),
    .upd_taken(s_upd_taken), .upd_target(s_upd_target), .upd_mispred(s_upd_mispred),
    .mispred_count(s_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    res_valid       = '0;
    res_is_branch   = '0;
    res_taken       = '0;
    res_pc          = '0;
    res_target      = '0;
    res_pred_taken  = '0;
    res_pred_target = '0;
  endtask

  task automatic lane(input int i, input logic vld, input logic br, input logic tk,
                      input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt,
                      input logic ptk, input logic [PC_W-1:0] ptgt);
    res_valid[i]                     = vld;
    res_is_branch[i]                 = br;
    res_taken[i]                     = tk;
    res_pc[i*PC_W +: PC_W]           = pc;
    res_target[i*PC_W +: PC_W]       = tgt;
    res_pred_taken[i]                = ptk;
    res_pred_target[i*PC_W +: PC_W]  = ptgt;
  endtask

  initial begin
    upd_ready = 1'b0;
    clr();

    // 1. Reset with random inputs
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      res_valid       = LANES'($urandom);
      res_is_branch   = LANES'($urandom);
      res_taken       = LANES'($urandom);
      res_pc          = {$urandom, $urandom};
      res_target      = {$urandom, $urandom};
      res_pred_taken  = LANES'($urandom);
      res_pred_target = {$urandom, $urandom};
      upd_ready       = 1'($urandom);
      step();
    end
    chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst_redirect_pc",    64'(redirect_pc),    64'd0);
    chk("rst_upd_valid",      64'(upd_valid),      64'd0);
    chk("rst_upd_pc",         64'(upd_pc),         64'd0);
    chk("rst_count",          64'(mispred_count),  64'd0);
    chk("rst_stall",          64'(stall),          64'd0);
    clr();
    upd_ready = 1'b0;
    rst = 1'b1;
    step();

    // 2. Correct predictions
    lane(0, 1, 1, 1, 32'h100, 32'h200, 1, 32'h200);
    lane(1, 1, 1, 0, 32'h104, 32'h0,   0, 32'h0);
    step();
    clr();
    chk("ok_no_redirect", 64'(redirect_valid), 64'd0);
    chk("ok_head_valid",  64'(upd_valid),      64'd1);
    chk("ok_head0_pc",    64'(upd_pc),         64'h100);
    chk("ok_head0_taken", 64'(upd_taken),      64'd1);
    chk("ok_head0_tgt",   64'(upd_target),     64'h200);
    chk("ok_head0_mis",   64'(upd_mispred),    64'd0);
    upd_ready = 1'b1;
    step();
    chk("ok_head1_pc",    64'(upd_pc),         64'h104);
    chk("ok_head1_taken", 64'(upd_taken),      64'd0);
    step();
    chk("ok_drained",     64'(upd_valid),      64'd0);
    upd_ready = 1'b0;

    // 3. Direction mispredict on lane 0 kills lane 1
    lane(0, 1, 1, 0, 32'h300, 32'h380, 1, 32'h380);
    lane(1, 1, 1, 1, 32'h304, 32'h700, 1, 32'h700);
    step();
    clr();
    chk("kill_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("kill_redirect_pc",    64'(redirect_pc),    64'h304);
    chk("kill_head_pc",        64'(upd_pc),         64'h300);
    chk("kill_head_mis",       64'(upd_mispred),    64'd1);
    chk("kill_count",          64'(mispred_count),  64'd1);
    upd_ready = 1'b1;
    step();
    chk("kill_one_record",     64'(upd_valid),      64'd0);
    chk("kill_pulse_end",      64'(redirect_valid), 64'd0);
    upd_ready = 1'b0;

    // 4. Target mispredict on lane 1, lane 0 a non-branch
    lane(0, 1, 0, 0, 32'h3fc, 32'h0,   0, 32'h0);
    lane(1, 1, 1, 1, 32'h400, 32'h480, 1, 32'h440);
    step();
    clr();
    chk("tgt_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("tgt_redirect_pc",    64'(redirect_pc),    64'h480);
    chk("tgt_head_pc",        64'(upd_pc),         64'h400);
    chk("tgt_head_tgt",       64'(upd_target),     64'h480);
    chk("tgt_count",          64'(mispred_count),  64'd2);
    upd_ready = 1'b1;
    step();
    chk("tgt_one_record",     64'(upd_valid),      64'd0);
    upd_ready = 1'b0;

    // pc+4 wraps modulo 2^PC_W
    lane(0, 1, 1, 0, 32'hffff_fffc, 32'h10, 1, 32'h10);
    step();
    clr();
    chk("wrap_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("wrap_redirect_pc",    64'(redirect_pc),    64'h0);
    chk("wrap_count",          64'(mispred_count),  64'd3);
    upd_ready = 1'b1;
    step();
    upd_ready = 1'b0;

    // 5. Fill to full, stalled input ignored, drain across pointer wrap
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("fill_stall_%0d", n), 64'(stall), 64'd0);
      lane(0, 1, 1, 0, 32'h1000 + 32'(8*n),     32'h0, 0, 32'h0);
      lane(1, 1, 1, 0, 32'h1000 + 32'(8*n + 4), 32'h0, 0, 32'h0);
      step();
    end
    clr();
    chk("full_stall", 64'(stall), 64'd1);
    lane(0, 1, 1, 1, 32'h2000, 32'h2100, 0, 32'h0);
    lane(1, 1, 1, 1, 32'h2004, 32'h2200, 0, 32'h0);
    step();
    clr();
    chk("full_no_redirect", 64'(redirect_valid), 64'd0);
    chk("full_count_hold",  64'(mispred_count),  64'd3);
    chk("full_still_stall", 64'(stall),          64'd1);
    upd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_pc_%0d", k), 64'(upd_pc), 64'h1000 + 64'(4*k));
      step();
      if (k == 0) chk("drain_stall_after_1pop", 64'(stall), 64'd1);
      if (k == 1) chk("drain_stall_after_2pop", 64'(stall), 64'd0);
    end
    chk("drain_empty", 64'(upd_valid), 64'd0);

    // 6. Saturation on the CNT_W=2 instance, then mid-stream reset
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("sat_start", 64'(s_count), 64'd0);
    for (int c = 0; c < 4; c++) begin
      lane(0, 1, 1, 1, 32'h500, 32'h600, 0, 32'h0);
      step();
      chk($sformatf("sat_count_%0d", c), 64'(s_count),       (c < 3) ? 64'(c + 1) : 64'd3);
      chk($sformatf("wide_count_%0d", c), 64'(mispred_count), 64'(c + 1));
    end
    chk("sat_redirect_pc", 64'(redirect_pc), 64'h600);
    upd_ready = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    clr();
    chk("midrst_upd_valid", 64'(upd_valid),      64'd0);
    chk("midrst_count",     64'(mispred_count),  64'd0);
    chk("midrst_sat_count", 64'(s_count),        64'd0);
    chk("midrst_redirect",  64'(redirect_valid), 64'd0);
    step();
    chk("post_rst_empty",   64'(upd_valid),      64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
